// File: rtl/sc_flagpacer_pkg.sv
// rtl/sc_flagpacer_pkg.sv - shared constants and state encoding for the flag pacer
// Purpose: state encoding, toggle-counter width and default tick constants.
// Ports: none (package).
package sc_flagpacer_pkg;

  localparam int STATE_W           = 3;
  localparam int TOGGLECNT_W       = 8;
  localparam int DEF_HIGH_TICKS    = 25_000_000;
  localparam int DEF_LOW_TICKS     = 25_000_000;
  localparam int DEF_TIMEOUT_TICKS = 16;
  localparam int DEF_CNT_W         = 26;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_LOW  = 3'd1,
    ST_PULSE_ON  = 3'd2,
    ST_WAIT_RISE = 3'd3,
    ST_WAIT_HIGH = 3'd4,
    ST_PULSE_OFF = 3'd5,
    ST_WAIT_FALL = 3'd6,
    ST_ERROR     = 3'd7
  } state_e;

endpackage

// File: rtl/sc_flagpacer_edgedet.sv
// rtl/sc_flagpacer_edgedet.sv - input register and rise/fall detector for the returned toggle signal
// Purpose: registers the toggling signal once (s) and keeps its previous value
//          (s_d) to produce single-cycle rise/fall strobes.
// Ports:
//   clk     in   system clock
//   rst     in   asynchronous active-high reset
//   sig_in  in   toggling signal from the toggler (same clock domain)
//   s       out  registered signal used for all decisions
//   rise    out  s & ~s_d
//   fall    out  ~s & s_d
module sc_flagpacer_edgedet (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic s,
  output logic rise,
  output logic fall
);

  // in_q holds s, in_prev_q holds s_d (s one cycle earlier).
  logic in_q, in_d;
  logic in_prev_q, in_prev_d;

  always_comb begin
    in_d      = sig_in;
    in_prev_d = in_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_q      <= 1'b0;
      in_prev_q <= 1'b0;
    end else begin
      in_q      <= in_d;
      in_prev_q <= in_prev_d;
    end
  end

  assign s    = in_q;
  assign rise = in_q & ~in_prev_q;
  assign fall = ~in_q & in_prev_q;

endmodule

// File: rtl/sc_flagpacer_cambiante.sv
// rtl/sc_flagpacer_cambiante.sv - closed-loop pacer and monitor for the toggling-signal FSM
// Purpose: issues one-cycle active-low FLAG pulses to set the high/low phase
//          lengths of the toggler, checks each pulse is answered within a
//          timeout, and measures the last high phase and completed pulses.
// Ports:
//   SC_STATEMACHINEBACKG_CLOCK_50       in   50 MHz system clock
//   SC_STATEMACHINEBACKG_RESET_InHigh   in   asynchronous active-high reset
//   SC_FLAGPACER_SenalCambiante_In      in   toggling signal from the toggler
//   SC_FLAGPACER_Enable_InHigh          in   run enable
//   SC_FLAGPACER_FLAG_OutLow            out  one-cycle active-low toggle request
//   SC_FLAGPACER_HighCount_Out          out  last completed high length, saturating
//   SC_FLAGPACER_ToggleCount_Out        out  completed high pulses, wrapping
//   SC_FLAGPACER_Timeout_OutHigh        out  sticky timeout error
module sc_flagpacer_cambiante
  import sc_flagpacer_pkg::*;
#(
  parameter int HIGH_TICKS    = DEF_HIGH_TICKS,
  parameter int LOW_TICKS     = DEF_LOW_TICKS,
  parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic                   SC_STATEMACHINEBACKG_CLOCK_50,
  input  logic                   SC_STATEMACHINEBACKG_RESET_InHigh,
  input  logic                   SC_FLAGPACER_SenalCambiante_In,
  input  logic                   SC_FLAGPACER_Enable_InHigh,
  output logic                   SC_FLAGPACER_FLAG_OutLow,
  output logic [CNT_W-1:0]       SC_FLAGPACER_HighCount_Out,
  output logic [TOGGLECNT_W-1:0] SC_FLAGPACER_ToggleCount_Out,
  output logic                   SC_FLAGPACER_Timeout_OutHigh
);

  // Phase counter starts at 0 on entry, so expiry is at TICKS-1.
  localparam logic [CNT_W-1:0] HIGH_LAST = CNT_W'(HIGH_TICKS - 1);
  localparam logic [CNT_W-1:0] LOW_LAST  = CNT_W'(LOW_TICKS - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_TICKS - 1);

  logic clk, rst, en, s, rise, fall;
  assign clk = SC_STATEMACHINEBACKG_CLOCK_50;
  assign rst = SC_STATEMACHINEBACKG_RESET_InHigh;
  assign en  = SC_FLAGPACER_Enable_InHigh;

  sc_flagpacer_edgedet u_edgedet (
    .clk    (clk),
    .rst    (rst),
    .sig_in (SC_FLAGPACER_SenalCambiante_In),
    .s      (s),
    .rise   (rise),
    .fall   (fall)
  );

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     flag_q, flag_d;
  logic                     timeout_q, timeout_d;
  logic [CNT_W-1:0]         hcnt_q, hcnt_d;
  logic [CNT_W-1:0]         high_q, high_d;
  logic [TOGGLECNT_W-1:0]   tog_q, tog_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (en) state_d = s ? ST_WAIT_HIGH : ST_WAIT_LOW;
      end
      ST_WAIT_LOW: begin
        // An edge seen on the expiry cycle wins over the pulse.
        if (s) begin
          state_d = ST_WAIT_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == LOW_LAST) begin
          state_d = ST_PULSE_ON;
          cnt_d   = '0;
        end
      end
      ST_PULSE_ON: begin
        state_d = ST_WAIT_RISE;
        cnt_d   = '0;
      end
      ST_WAIT_RISE: begin
        if (s) begin
          state_d = ST_WAIT_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          state_d = ST_ERROR;
          cnt_d   = '0;
        end
      end
      ST_WAIT_HIGH: begin
        if (!s) begin
          state_d = ST_WAIT_LOW;
          cnt_d   = '0;
        end else if (cnt_q == HIGH_LAST) begin
          state_d = ST_PULSE_OFF;
          cnt_d   = '0;
        end
      end
      ST_PULSE_OFF: begin
        state_d = ST_WAIT_FALL;
        cnt_d   = '0;
      end
      ST_WAIT_FALL: begin
        if (!s) begin
          state_d = ST_WAIT_LOW;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          state_d = ST_ERROR;
          cnt_d   = '0;
        end
      end
      ST_ERROR: begin
        cnt_d = '0;
        if (!en) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Dropping enable aborts everything except a latched error.
    if (!en && state_q != ST_ERROR) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end

    // Outputs are registered from the next state so they line up with it.
    flag_d    = !(state_d == ST_PULSE_ON || state_d == ST_PULSE_OFF);
    timeout_d = (state_d == ST_ERROR);
  end

  // High-phase measurement runs regardless of the pacing state.
  always_comb begin
    hcnt_d = hcnt_q;
    high_d = high_q;
    tog_d  = tog_q;
    if (rise) begin
      // The rise cycle itself is the first high cycle.
      hcnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (s && hcnt_q != '1) begin
      hcnt_d = hcnt_q + 1'b1;
    end
    if (fall) begin
      high_d = hcnt_q;
      tog_d  = tog_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      flag_q    <= 1'b1;
      timeout_q <= 1'b0;
      hcnt_q    <= '0;
      high_q    <= '0;
      tog_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      flag_q    <= flag_d;
      timeout_q <= timeout_d;
      hcnt_q    <= hcnt_d;
      high_q    <= high_d;
      tog_q     <= tog_d;
    end
  end

  assign SC_FLAGPACER_FLAG_OutLow     = flag_q;
  assign SC_FLAGPACER_HighCount_Out   = high_q;
  assign SC_FLAGPACER_ToggleCount_Out = tog_q;
  assign SC_FLAGPACER_Timeout_OutHigh = timeout_q;

endmodule

// File: tb/tb_sc_flagpacer_cambiante.sv
// tb/tb_sc_flagpacer_cambiante.sv - self-checking bench for sc_flagpacer_cambiante
module tb_sc_flagpacer_cambiante;

  localparam int HT = 4;
  localparam int LT = 3;
  localparam int TT = 8;
  localparam int CW = 8;
  localparam int PERIOD = HT + LT + 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          start_btn = 1'b1;
  logic          force_hi = 1'b0;
  logic          tog;
  logic          sig_in;
  logic          flag;
  logic [CW-1:0] hc;
  logic [7:0]    tc;
  logic          to;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int pulse_cyc[$];
  int run = 0, ref_last = 0, ref_falls = 0;
  logic prev_in = 1'b0;
  logic mon_hc = 1'b0;
  int hc_bad = 0;

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign sig_in = force_hi | tog;

  // Toggler: flips its output one cycle after a sampled low FLAG, if started.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tog <= 1'b0;
    else if (start_btn && !flag) tog <= ~tog;
  end

  sc_flagpacer_cambiante #(
    .HIGH_TICKS(HT), .LOW_TICKS(LT), .TIMEOUT_TICKS(TT), .CNT_W(CW)
  ) dut (
    .SC_STATEMACHINEBACKG_CLOCK_50     (clk),
    .SC_STATEMACHINEBACKG_RESET_InHigh (rst),
    .SC_FLAGPACER_SenalCambiante_In    (sig_in),
    .SC_FLAGPACER_Enable_InHigh        (en),
    .SC_FLAGPACER_FLAG_OutLow          (flag),
    .SC_FLAGPACER_HighCount_Out        (hc),
    .SC_FLAGPACER_ToggleCount_Out      (tc),
    .SC_FLAGPACER_Timeout_OutHigh      (to)
  );

  // Reference: length of each run of ones on the input and number of runs ended.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      run <= 0; ref_last <= 0; ref_falls <= 0; prev_in <= 1'b0;
    end else begin
      if (sig_in) run <= (run < 255) ? run + 1 : 255;
      else begin
        run <= 0;
        if (prev_in) begin
          ref_last  <= run;
          ref_falls <= ref_falls + 1;
        end
      end
      prev_in <= sig_in;
    end
  end

  always @(negedge clk) begin
    if (flag !== 1'b1) pulse_cyc.push_back(cyc);
    if (mon_hc && hc !== 8'd0 && hc !== 8'(HT + 3)) hc_bad <= hc_bad + 1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    en = 1'b0; force_hi = 1'b0; start_btn = 1'b1; rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    pulse_cyc.delete();
  endtask

  task automatic test_reset();
    tick(2);
    tests++; if (flag !== 1'b1) begin fails++; $display("FAIL reset_flag: got %b expected 1", flag); end
    tests++; if (hc !== 8'd0) begin fails++; $display("FAIL reset_highcount: got %0d expected 0", hc); end
    tests++; if (tc !== 8'd0) begin fails++; $display("FAIL reset_togglecount: got %0d expected 0", tc); end
    tests++; if (to !== 1'b0) begin fails++; $display("FAIL reset_timeout: got %b expected 0", to); end
    rst = 1'b0;
    tick(6);
    tests++; if (pulse_cyc.size() != 0) begin fails++; $display("FAIL idle_no_pulse: got %0d pulses expected 0", pulse_cyc.size()); end
  endtask

  task automatic test_first_pulse();
    int e, bad;
    do_reset();
    tick($urandom_range(1, 6));
    en = 1'b1; e = cyc;
    tick(10);
    tests++; if (tc !== 8'd0 || hc !== 8'd0) begin fails++; $display("FAIL first_before_fall: got hc=%0d tc=%0d expected 0 0", hc, tc); end
    tests++; if (sig_in !== 1'b1) begin fails++; $display("FAIL first_high_level: got %b expected 1", sig_in); end
    tick(6);
    tests++; if (hc !== 8'(HT + 3)) begin fails++; $display("FAIL first_highcount: got %0d expected %0d", hc, HT + 3); end
    tests++; if (tc !== 8'd1) begin fails++; $display("FAIL first_togglecount: got %0d expected 1", tc); end
    tests++; if (sig_in !== 1'b0) begin fails++; $display("FAIL first_low_level: got %b expected 0", sig_in); end
    tick(29);
    bad = 0;
    for (int k = 0; k < 7; k++) begin
      int exp_c;
      exp_c = e + ((k % 2 == 0) ? 4 : HT + 7) + PERIOD * (k / 2);
      if (k >= pulse_cyc.size() || pulse_cyc[k] != exp_c) bad++;
    end
    tests++; if (bad != 0 || pulse_cyc.size() != 7) begin fails++; $display("FAIL first_pulse_times: got %0d wrong of %0d pulses expected 0 wrong of 7", bad, pulse_cyc.size()); end
  endtask

  task automatic test_many_pulses();
    int n, bound, bad;
    do_reset();
    hc_bad = 0; mon_hc = 1'b1;
    en = 1'b1;
    n = 0; bound = 300 * PERIOD + 200;
    while (ref_falls < 300 && n < bound) begin
      tick(1);
      n++;
    end
    tests++; if (n >= bound) begin fails++; $display("FAIL many_bound: got %0d falls expected 300", ref_falls); end
    tick(3);
    mon_hc = 1'b0;
    tests++; if (tc !== 8'(300)) begin fails++; $display("FAIL many_togglecount: got %0d expected %0d", tc, 300 % 256); end
    tests++; if (hc !== 8'(HT + 3) || hc_bad != 0) begin fails++; $display("FAIL many_highcount: got %0d (%0d bad samples) expected %0d", hc, hc_bad, HT + 3); end
    bad = 0;
    for (int i = 2; i < pulse_cyc.size(); i++)
      if (pulse_cyc[i] - pulse_cyc[i-2] != PERIOD) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL many_period: got %0d bad intervals expected 0", bad); end
  endtask

  task automatic test_timeout();
    int e;
    do_reset();
    start_btn = 1'b0;
    tick($urandom_range(1, 5));
    en = 1'b1; e = cyc;
    tick(4);
    tests++; if (flag !== 1'b0) begin fails++; $display("FAIL to_on_pulse: got %b expected 0", flag); end
    tick(TT);
    tests++; if (to !== 1'b0) begin fails++; $display("FAIL to_early: got %b expected 0", to); end
    tick(1);
    tests++; if (to !== 1'b1) begin fails++; $display("FAIL to_set: got %b expected 1", to); end
    tick($urandom_range(2, 10));
    tests++; if (to !== 1'b1 || pulse_cyc.size() != 1) begin fails++; $display("FAIL to_sticky: got to=%b pulses=%0d expected 1 1", to, pulse_cyc.size()); end
    en = 1'b0;
    tick(1);
    tests++; if (to !== 1'b0) begin fails++; $display("FAIL to_clear: got %b expected 0", to); end
    start_btn = 1'b1; pulse_cyc.delete();
    en = 1'b1; e = cyc;
    tick(5);
    tests++; if (pulse_cyc.size() != 1 || pulse_cyc[0] != e + 4) begin fails++; $display("FAIL to_restart: got %0d pulses expected one at +4", pulse_cyc.size()); end
  endtask

  task automatic test_enable_drop();
    int e, r, n0, rr;
    do_reset();
    tick($urandom_range(1, 5));
    en = 1'b1; e = cyc;
    r = $urandom_range(0, 3);
    tick(7 + r);
    en = 1'b0;
    n0 = pulse_cyc.size();
    tick(10);
    tests++; if (pulse_cyc.size() != n0 || n0 != 1) begin fails++; $display("FAIL drop_no_off_pulse: got %0d pulses expected 1 (drop offset %0d)", pulse_cyc.size(), r); end
    tests++; if (sig_in !== 1'b1) begin fails++; $display("FAIL drop_level: got %b expected 1", sig_in); end
    en = 1'b1; rr = cyc;
    tick(9);
    tests++; if (pulse_cyc.size() != n0 + 1 || pulse_cyc[n0] != rr + HT + 1) begin fails++; $display("FAIL reenable_off_pulse: got %0d pulses expected one at +%0d", pulse_cyc.size(), HT + 1); end
    tests++; if (hc !== 8'(ref_last) || ref_last != rr - e + 1) begin fails++; $display("FAIL reenable_highcount: got %0d expected %0d", hc, rr - e + 1); end
    tests++; if (tc !== 8'(ref_falls) || ref_falls != 1) begin fails++; $display("FAIL reenable_togglecount: got %0d expected 1", tc); end
  endtask

  task automatic test_forced_high();
    int e, f, len, n0;
    do_reset();
    tick($urandom_range(1, 5));
    en = 1'b1; e = cyc;
    tick(14);
    n0 = pulse_cyc.size();
    f = e + 14 + $urandom_range(0, 1);
    len = $urandom_range(1, 4);
    tick(f - cyc);
    force_hi = 1'b1;
    tick(len);
    force_hi = 1'b0;
    tick(6);
    tests++; if (n0 != 2 || pulse_cyc.size() != n0 + 1 || pulse_cyc[n0] != f + len + 5) begin fails++; $display("FAIL forced_pulse: got %0d pulses expected next on at +%0d (len %0d)", pulse_cyc.size(), len + 5, len); end
    tests++; if (hc !== 8'(len)) begin fails++; $display("FAIL forced_highcount: got %0d expected %0d", hc, len); end
    tests++; if (tc !== 8'(ref_falls) || ref_falls != 2) begin fails++; $display("FAIL forced_togglecount: got %0d expected 2", tc); end
  endtask

  task automatic test_reset_mid();
    int e, n0, rr;
    do_reset();
    tick($urandom_range(1, 5));
    en = 1'b1; e = cyc;
    tick(20 + $urandom_range(0, 3));
    tests++; if (hc !== 8'(HT + 3) || tc !== 8'd1) begin fails++; $display("FAIL mid_before: got hc=%0d tc=%0d expected %0d 1", hc, tc, HT + 3); end
    rst = 1'b1; en = 1'b0;
    #1;
    tests++; if (flag !== 1'b1 || hc !== 8'd0 || tc !== 8'd0 || to !== 1'b0) begin fails++; $display("FAIL mid_reset: got flag=%b hc=%0d tc=%0d to=%b expected 1 0 0 0", flag, hc, tc, to); end
    n0 = pulse_cyc.size();
    tick(3);
    rst = 1'b0;
    tick(8);
    tests++; if (pulse_cyc.size() != n0) begin fails++; $display("FAIL mid_no_pulse: got %0d pulses expected %0d", pulse_cyc.size(), n0); end
    en = 1'b1; rr = cyc;
    tick(5);
    tests++; if (pulse_cyc.size() != n0 + 1 || pulse_cyc[n0] != rr + 4) begin fails++; $display("FAIL mid_resequence: got %0d pulses expected one at +4", pulse_cyc.size() - n0); end
  endtask

  initial begin
    test_reset();
    test_first_pulse();
    test_many_pulses();
    test_timeout();
    test_enable_drop();
    test_forced_high();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
